// File: rtl/program_counter_stack.sv
// Program counter for the sequencer datapath with relative branching and a
// hardware return-address stack. One command executes per clock edge under a
// fixed priority: clear > ret > call > load > branch > inc > hold.
// Stack misuse (call on full, ret on empty) leaves the PC and stack alone and
// raises a sticky Error that only clear or reset can drop.

module program_counter_stack #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             ResetVal,
    input  logic [WIDTH-1:0]             LoadVal,
    input  logic [WIDTH-1:0]             Offset,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         branch,
    input  logic                         inc,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             PCoutput,
    output logic [$clog2(DEPTH+1)-1:0]   StackDepth,
    output logic                         StackFull,
    output logic                         StackEmpty,
    output logic                         Error
);

    // Depth counter must represent 0..DEPTH inclusive; stack index 0..DEPTH-1.
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);
    localparam logic [DW-1:0]    ONE_DW  = DW'(1);

    // Winning command after priority resolution.
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_CLEAR,
        CMD_RET,
        CMD_CALL,
        CMD_LOAD,
        CMD_BRANCH,
        CMD_INC
    } cmd_e;

    // Architectural state.
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q,   err_d;

    // Return-address storage; entry depth_q-1 is the top of stack.
    logic [WIDTH-1:0] stack_q [DEPTH];

    cmd_e             cmd;
    logic             full;
    logic             empty;
    logic             push_en;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] ret_addr;

    // Status decodes taken straight from the registered depth.
    assign full     = (depth_q == DEPTH_W);
    assign empty    = (depth_q == '0);

    // Push lands one above the current top; pop reads the current top.
    // When empty, top_idx wraps to a meaningless slot, but it is never used then.
    assign push_idx = IW'(depth_q);
    assign top_idx  = IW'(depth_q - ONE_DW);
    assign ret_addr = pc_q + STEP_W;

    // Resolve simultaneous commands to the single highest-priority one.
    always_comb begin
        cmd = CMD_HOLD;
        if (clear) begin
            cmd = CMD_CLEAR;
        end else if (ret) begin
            cmd = CMD_RET;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (branch) begin
            cmd = CMD_BRANCH;
        end else if (inc) begin
            cmd = CMD_INC;
        end
    end

    // Next-state computation for PC, stack depth, Error and the push strobe.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case below can leave one unassigned and infer a latch.
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;

        unique case (cmd)
            CMD_CLEAR: begin
                pc_d    = ResetVal;
                depth_d = '0;
                err_d   = 1'b0;
            end
            CMD_RET: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - ONE_DW;
                end
            end
            CMD_CALL: begin
                // A call on a full stack is refused outright: no push, no
                // overwrite of the oldest entry, and the PC stays put.
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    pc_d    = LoadVal;
                    depth_d = depth_q + ONE_DW;
                end
            end
            CMD_LOAD:   pc_d = LoadVal;
            CMD_BRANCH: pc_d = pc_q + Offset;
            CMD_INC:    pc_d = pc_q + STEP_W;
            CMD_HOLD:   ;
            default:    ;
        endcase
    end

    // PC, depth and sticky Error registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            pc_q    <= RESET_VAL;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage written only by a legal call.
    // NOTE: the stack array is deliberately not reset; depth_q alone decides
    // which entries are valid, so clearing the contents would buy nothing.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= ret_addr;
        end
    end

    assign PCoutput   = pc_q;
    assign StackDepth = depth_q;
    assign StackFull  = full;
    assign StackEmpty = empty;
    assign Error      = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed scenarios followed by
// randomized command streams, all compared against a queue-based reference model.

module tb_program_counter_stack;

    localparam int WIDTH = 8;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] ResetVal;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Offset;
    logic             clear;
    logic             load;
    logic             branch;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] PCoutput;
    logic [2:0]       StackDepth;
    logic             StackFull;
    logic             StackEmpty;
    logic             Error;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_pc;
    int m_stk[$];
    bit m_err;

    program_counter_stack #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .DEPTH    (DEPTH),
        .RESET_VAL(8'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ResetVal  (ResetVal),
        .LoadVal   (LoadVal),
        .Offset    (Offset),
        .clear     (clear),
        .load      (load),
        .branch    (branch),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .PCoutput  (PCoutput),
        .StackDepth(StackDepth),
        .StackFull (StackFull),
        .StackEmpty(StackEmpty),
        .Error     (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    32'(PCoutput),   32'(m_pc));
        check({tag, ".depth"}, 32'(StackDepth), 32'(m_stk.size()));
        check({tag, ".full"},  32'(StackFull),  32'(m_stk.size() == DEPTH));
        check({tag, ".empty"}, 32'(StackEmpty), 32'(m_stk.size() == 0));
        check({tag, ".err"},   32'(Error),      32'(m_err));
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    // Reference behaviour: priority clear > ret > call > load > branch > inc.
    task automatic model_step(input bit c_clr, input bit c_ret, input bit c_call,
                              input bit c_load, input bit c_br, input bit c_inc,
                              input int lv, input int ov, input int rv);
        if (c_clr) begin
            m_pc = rv;
            m_stk.delete();
            m_err = 1'b0;
        end else if (c_ret) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (c_call) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else begin
                m_stk.push_back((m_pc + STEP) % MODV);
                m_pc = lv;
            end
        end else if (c_load) begin
            m_pc = lv;
        end else if (c_br) begin
            m_pc = (m_pc + ov) % MODV;
        end else if (c_inc) begin
            m_pc = (m_pc + STEP) % MODV;
        end
    endtask

    // Drive one command set for one edge, advance the model, compare after the edge.
    task automatic apply(input string tag, input bit c_clr, input bit c_ret, input bit c_call,
                         input bit c_load, input bit c_br, input bit c_inc,
                         input int lv, input int ov, input int rv);
        clear    = c_clr;
        ret      = c_ret;
        call     = c_call;
        load     = c_load;
        branch   = c_br;
        inc      = c_inc;
        LoadVal  = WIDTH'(lv);
        Offset   = WIDTH'(ov);
        ResetVal = WIDTH'(rv);
        model_step(c_clr, c_ret, c_call, c_load, c_br, c_inc, lv, ov, rv);
        @(posedge clk);
        #1;
        clear  = 1'b0;
        ret    = 1'b0;
        call   = 1'b0;
        load   = 1'b0;
        branch = 1'b0;
        inc    = 1'b0;
        check_model(tag);
    endtask

    // Convenience wrappers for single commands.
    task automatic do_inc(input string tag);           apply(tag, 0,0,0,0,0,1, 0,0,0);  endtask
    task automatic do_load(input string tag, int v);   apply(tag, 0,0,0,1,0,0, v,0,0);  endtask
    task automatic do_branch(input string tag, int o); apply(tag, 0,0,0,0,1,0, 0,o,0);  endtask
    task automatic do_call(input string tag, int v);   apply(tag, 0,0,1,0,0,0, v,0,0);  endtask
    task automatic do_ret(input string tag);           apply(tag, 0,1,0,0,0,0, 0,0,0);  endtask
    task automatic do_clear(input string tag, int r);  apply(tag, 1,0,0,0,0,0, 0,0,r);  endtask

    // Assert reset between edges and confirm it acts without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        ResetVal = '0;
        LoadVal  = '0;
        Offset   = '0;
        clear    = 1'b0;
        load     = 1'b0;
        branch   = 1'b0;
        inc      = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_model("por");
        reset = 1'b1;

        // 1: mid-run async reset, then three increments.
        do_load("t1_load", 77);
        do_call("t1_call", 100);
        async_reset("t1_rst");
        check("t1_rst_pc", 32'(PCoutput), 32'd0);
        check("t1_rst_empty", 32'(StackEmpty), 32'd1);
        repeat (3) do_inc("t1_inc");
        check("t1_pc3", 32'(PCoutput), 32'd3);

        // 2: load, increment, negative branch, wrap.
        do_load("t2_load200", 200);
        do_inc("t2_inc");
        check("t2_201", 32'(PCoutput), 32'd201);
        do_branch("t2_br", 8'hFE);
        check("t2_199", 32'(PCoutput), 32'd199);
        do_load("t2_load255", 255);
        do_inc("t2_wrap");
        check("t2_wrap0", 32'(PCoutput), 32'd0);

        // 3: nested call/return.
        do_load("t3_load10", 10);
        do_call("t3_call50", 50);
        check("t3_pc50", 32'(PCoutput), 32'd50);
        do_call("t3_call90", 90);
        check("t3_depth2", 32'(StackDepth), 32'd2);
        do_ret("t3_ret1");
        check("t3_pc51", 32'(PCoutput), 32'd51);
        do_ret("t3_ret2");
        check("t3_pc11", 32'(PCoutput), 32'd11);

        // 4: fill the stack, overflow, unwind; Error stays sticky.
        do_clear("t4_clr", 0);
        do_call("t4_c20", 20);
        do_call("t4_c30", 30);
        do_call("t4_c40", 40);
        do_call("t4_c50", 50);
        check("t4_full", 32'(StackFull), 32'd1);
        do_call("t4_c99", 99);
        check("t4_ovf_pc", 32'(PCoutput), 32'd50);
        check("t4_ovf_err", 32'(Error), 32'd1);
        do_ret("t4_r41");
        check("t4_pc41", 32'(PCoutput), 32'd41);
        do_ret("t4_r31");
        do_ret("t4_r21");
        do_ret("t4_r1");
        check("t4_pc1", 32'(PCoutput), 32'd1);
        check("t4_err_sticky", 32'(Error), 32'd1);

        // 5: underflow then clear.
        do_load("t5_load7", 7);
        do_ret("t5_uf");
        check("t5_pc7", 32'(PCoutput), 32'd7);
        do_clear("t5_clr", 12);
        check("t5_pc12", 32'(PCoutput), 32'd12);
        check("t5_err0", 32'(Error), 32'd0);

        // 6: priority combinations.
        do_call("t6_pre", 33);
        apply("t6_clr_call_inc", 1,0,1,0,0,1, 70,0,5);
        check("t6_clr_pc", 32'(PCoutput), 32'd5);
        check("t6_clr_depth", 32'(StackDepth), 32'd0);
        apply("t6_call_load", 0,0,1,1,0,0, 60,0,0);
        check("t6_call_pc", 32'(PCoutput), 32'd60);
        check("t6_call_depth", 32'(StackDepth), 32'd1);
        do_ret("t6_drain");
        apply("t6_ret_inc", 0,1,0,0,0,1, 0,0,0);
        check("t6_reti_err", 32'(Error), 32'd1);
        apply("t6_ld_br_inc", 0,0,0,1,1,1, 140,3,0);
        check("t6_ld_pc", 32'(PCoutput), 32'd140);

        // Randomized command streams with occasional asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            int  lv, ov, rv;
            bit  c_clr, c_ret, c_call, c_load, c_br, c_inc;
            lv     = int'($urandom_range(0, MODV - 1));
            ov     = ($urandom_range(0, 3) == 0) ? 8'hFF : int'($urandom_range(0, MODV - 1));
            rv     = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, MODV - 1));
            c_clr  = ($urandom_range(0, 19) == 0);
            c_ret  = ($urandom_range(0, 3) == 0);
            c_call = ($urandom_range(0, 2) == 0);
            c_load = ($urandom_range(0, 5) == 0);
            c_br   = ($urandom_range(0, 4) == 0);
            c_inc  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                apply("rnd", c_clr, c_ret, c_call, c_load, c_br, c_inc, lv, ov, rv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the sequencer datapath.
- Supports width, step and stack depth as parameters.
- Adds relative branching, a hardware call/return stack, and full/empty/error status alongside the existing clear/load/increment functions.
- Drives the instruction-memory address; the control FSM issues one command per clock.

Parameters:
WIDTH, 8, width of PC, LoadVal, ResetVal, Offset and stack entries
STEP, 1, increment added by inc; also the return-address offset pushed by call
DEPTH, 4, number of return-address stack entries (>=1)
RESET_VAL, 0, PC value forced by asynchronous reset

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-low reset
ResetVal  in  WIDTH  value loaded by synchronous clear
LoadVal  in  WIDTH  absolute target for load and call
Offset  in  WIDTH  two's-complement displacement for branch
clear  in  1  synchronous clear command
load  in  1  absolute jump command
branch  in  1  relative jump command
inc  in  1  increment command
call  in  1  push return address, jump to LoadVal
ret  in  1  pop return address into PC
PCoutput  out  WIDTH  current program counter
StackDepth  out  $clog2(DEPTH+1)  number of valid stack entries
StackFull  out  1  StackDepth == DEPTH
StackEmpty  out  1  StackDepth == 0
Error  out  1  sticky: call on full or ret on empty was attempted

Behaviour:
- Asynchronous reset (reset=0), takes effect immediately with no clock:
  - PCoutput=RESET_VAL, StackDepth=0, StackEmpty=1, StackFull=0, Error=0.
  - Stack contents are don't-care.
- Synchronous operation: all other updates occur on the rising edge of clk while reset=1.
- One command executes per edge. Fixed priority: clear > ret > call > load > branch > inc > hold.
- clear: PC<=ResetVal, StackDepth<=0, Error<=0.
- ret, not empty: PC<=top entry, StackDepth decrements.
- ret, empty: PC and stack unchanged, Error<=1.
- call, not full: push (PC+STEP) mod 2^WIDTH, PC<=LoadVal, StackDepth increments.
- call, full: PC and stack unchanged, Error<=1. No partial push, no overwrite of the oldest entry.
- load: PC<=LoadVal.
- branch: PC<=(PC+Offset) mod 2^WIDTH. Offset is two's complement, so 8'hFE is -2.
- inc: PC<=(PC+STEP) mod 2^WIDTH; wraps from max to 0 with no flag.
- No command asserted: all state holds.
- Error is sticky. Only clear or reset deasserts it. A legal call or ret does not clear it.
- Status outputs:
  - StackFull and StackEmpty are combinational decodes of the registered StackDepth.
  - PCoutput and StackDepth are registered, giving a one-cycle latency from command edge to output.
- Stack is LIFO. Entries are written only by a legal call. The top entry is at index StackDepth-1.
- Reset asserted mid-sequence discards all stack state immediately. Release of reset is assumed synchronous to clk by the system.

Test Plan:
Default parameters (WIDTH=8, STEP=1, DEPTH=4, RESET_VAL=0) unless noted.
1. Drop reset low between edges -> PCoutput=0, StackEmpty=1, StackDepth=0, Error=0 before the next edge. Release, inc x3 -> 3.
2. load LoadVal=200, then inc -> 201. branch Offset=8'hFE -> 199. load 255, inc -> 0 (wrap).
3. PC=10, call LoadVal=50 -> PC=50, StackDepth=1. call LoadVal=90 -> PC=90, depth 2. ret -> 51. ret -> 11, StackEmpty=1.
4. Four calls (targets 20,30,40,50) from PC=0 -> StackFull=1. Fifth call LoadVal=99 -> PC stays 50, Error=1, depth 4. Four rets -> PC 41, 31, 21, 1. Error remains 1.
5. ret with empty stack at PC=7 -> PC=7, Error=1. clear with ResetVal=12 -> PC=12, Error=0, depth 0.
6. Priority checks, each from a known state:
   - clear+call+inc -> clear result only.
   - call+load (LoadVal=60) -> call: PC=60, depth+1.
   - ret+inc with empty stack -> PC unchanged, Error=1.
   - load+branch+inc -> load result.
